// File: rtl/pdp8_mem_responder.sv
// -----------------------------------------------------------------------------
// pdp8_mem_responder
//
// Memory-side responder for a multicycle PDP-8-style datapath. It serves
// rden/wren requests against a 2^ADDR_W x DATA_W word store, inserts
// WAIT_CYCLES wait states before every array access and acknowledges each
// transaction with a one-cycle ready pulse. An indirect read (autoinc=1) of
// addresses 8..15 (octal 0010-0017) increments the stored word and returns
// the incremented value. A preload port writes the store while idle.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-low reset (memory contents preserved)
//   rden     read request, held until ready
//   wren     write request, held until ready
//   autoinc  marks a read as an indirect-operand fetch
//   addr     word address of the request
//   wdata    write data
//   rdata    read data register, updated only by completed reads
//   ready    one-cycle completion pulse
//   err      pulses with ready when rden and wren were both high
//   busy     high from the cycle after acceptance through the ready cycle
//   ld_en    preload strobe, honoured only in IDLE with no request present
//   ld_addr  preload address
//   ld_data  preload data
// -----------------------------------------------------------------------------
module pdp8_mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rden,
  input  logic              wren,
  input  logic              autoinc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_INCR,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_AINC,
    OP_ILLEGAL
  } op_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  state_t            state, state_n;
  op_t               op_q, op_sel;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  logic [DATA_W-1:0] temp;
  logic [3:0]        wcnt;

  logic              req;
  logic              in_ainc_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign req           = rden | wren;
  assign in_ainc_range = (addr >= ADDR_W'(8)) && (addr <= ADDR_W'(15));

  // Operation decoded from the request strobes; only latched in IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    op_sel = OP_READ;
    if (rden && wren)
      op_sel = OP_ILLEGAL;
    else if (wren)
      op_sel = OP_WRITE;
    else if (autoinc && in_ainc_range)
      op_sel = OP_AINC;
  end

  // Next-state and array write-port selection.
  always_comb begin
    state_n = state;
    mem_we  = 1'b0;
    mem_wa  = a_q;
    mem_wd  = d_q;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_n = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end else if (ld_en) begin
          // A request in the same cycle takes priority; the load is dropped.
          mem_we = 1'b1;
          mem_wa = ld_addr;
          mem_wd = ld_data;
        end
      end
      S_WAIT: begin
        if (wcnt <= 4'd1)
          state_n = S_ACCESS;
      end
      S_ACCESS: begin
        if (op_q == OP_WRITE)
          mem_we = 1'b1;
        state_n = (op_q == OP_AINC) ? S_INCR : S_RESP;
      end
      S_INCR: begin
        mem_we  = 1'b1;
        mem_wd  = temp + DATA_W'(1);
        state_n = S_RESP;
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign ready = (state == S_RESP);
  assign err   = ready && (op_q == OP_ILLEGAL);
  assign busy  = (state != S_IDLE);

  // Control state, operation latches and read data register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state <= S_IDLE;
      wcnt  <= 4'd0;
      rdata <= '0;
      op_q  <= OP_READ;
      a_q   <= '0;
      d_q   <= '0;
      temp  <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (req) begin
            a_q  <= addr;
            d_q  <= wdata;
            op_q <= op_sel;
            wcnt <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          wcnt <= wcnt - 4'd1;
        end
        S_ACCESS: begin
          if (op_q == OP_READ)
            rdata <= mem[a_q];
          else if (op_q == OP_AINC)
            temp <= mem[a_q];
        end
        S_INCR: begin
          rdata <= temp + DATA_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // NOTE: the array is deliberately not reset; gating the write with rst
  // keeps contents intact and makes an aborted write or increment a no-op.
  always_ff @(posedge clk) begin
    if (rst && mem_we)
      mem[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_pdp8_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_pdp8_mem_responder
//
// Bench for pdp8_mem_responder. Two instances are exercised: index 0 with
// WAIT_CYCLES=2 and index 1 with WAIT_CYCLES=0. A word-level model (array of
// stored words plus the expected rdata register) predicts every response and
// its completion cycle from the access rules.
// -----------------------------------------------------------------------------
module tb_pdp8_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rden    [2];
  logic        wren    [2];
  logic        autoinc [2];
  logic        ld_en   [2];
  logic [11:0] addr    [2];
  logic [11:0] wdata   [2];
  logic [11:0] ld_addr [2];
  logic [11:0] ld_data [2];
  logic [11:0] rdata   [2];
  logic        ready   [2];
  logic        err     [2];
  logic        busy    [2];

  int errors = 0;
  int checks = 0;

  // Reference model: stored words and the expected rdata register per DUT.
  logic [11:0] mm   [2][4096];
  logic [11:0] rd_m [2];

  always #5 clk = ~clk;

  pdp8_mem_responder #(.ADDR_W(12), .DATA_W(12), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .rden(rden[0]), .wren(wren[0]), .autoinc(autoinc[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
    .err(err[0]), .busy(busy[0]), .ld_en(ld_en[0]), .ld_addr(ld_addr[0]),
    .ld_data(ld_data[0])
  );

  pdp8_mem_responder #(.ADDR_W(12), .DATA_W(12), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .rden(rden[1]), .wren(wren[1]), .autoinc(autoinc[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
    .err(err[1]), .busy(busy[1]), .ld_en(ld_en[1]), .ld_addr(ld_addr[1]),
    .ld_data(ld_data[1])
  );

  function automatic int wv(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input int d);
    rden[d]    = 1'b0;
    wren[d]    = 1'b0;
    autoinc[d] = 1'b0;
    ld_en[d]   = 1'b0;
    addr[d]    = '0;
    wdata[d]   = '0;
    ld_addr[d] = '0;
    ld_data[d] = '0;
  endtask

  task automatic preload(input int d, input logic [11:0] a, input logic [11:0] v);
    ld_en[d]   = 1'b1;
    ld_addr[d] = a;
    ld_data[d] = v;
    tick();
    ld_en[d]   = 1'b0;
    mm[d][a]   = v;
  endtask

  // One complete transaction with optional same-cycle preload and an
  // address change after acceptance. Checks completion cycle, err, rdata,
  // busy throughout and the idle cycle following ready.
  task automatic txn(input int d, input bit rd, input bit wr, input bit ai,
                     input logic [11:0] a, input logic [11:0] wd,
                     input bit ld, input logic [11:0] lda, input logic [11:0] ldd,
                     input bit tog, input string nm);
    int          w, exp_cyc, got;
    bit          is_ainc, is_ill, busy_ok;
    logic [11:0] exp_rd;
    w       = wv(d);
    is_ill  = rd && wr;
    is_ainc = rd && !wr && ai && (a >= 12'd8) && (a <= 12'd15);
    exp_cyc = w + (is_ainc ? 3 : 2);
    if (!is_ill) begin
      if (wr) begin
        mm[d][a] = wd;
      end else begin
        if (is_ainc) mm[d][a] = mm[d][a] + 12'd1;
        rd_m[d] = mm[d][a];
      end
    end
    exp_rd = rd_m[d];

    rden[d]    = rd;
    wren[d]    = wr;
    autoinc[d] = ai;
    addr[d]    = a;
    wdata[d]   = wd;
    ld_en[d]   = ld;
    ld_addr[d] = lda;
    ld_data[d] = ldd;
    got     = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= 40 && got < 0; n++) begin
      tick();
      ld_en[d] = 1'b0;
      if (tog && n == 1) addr[d] = a ^ 12'o7777;
      if (busy[d] !== 1'b1) busy_ok = 1'b0;
      if (ready[d] === 1'b1) begin
        got        = n;
        rden[d]    = 1'b0;
        wren[d]    = 1'b0;
        autoinc[d] = 1'b0;
        checks++;
        if (err[d] !== is_ill) begin
          errors++;
          $display("FAIL %s err d%0d addr=%o: got %b exp %b", nm, d, a, err[d], is_ill);
        end
        checks++;
        if (rdata[d] !== exp_rd) begin
          errors++;
          $display("FAIL %s rdata d%0d addr=%o: got %o exp %o", nm, d, a, rdata[d], exp_rd);
        end
      end
    end
    checks++;
    if (got != exp_cyc) begin
      errors++;
      $display("FAIL %s ready_cycle d%0d addr=%o: got %0d exp %0d", nm, d, a, got, exp_cyc);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy d%0d addr=%o: low before ready, exp high", nm, d, a);
    end
    idle_inputs(d);
    tick();
    checks++;
    if (ready[d] !== 1'b0 || busy[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s post_idle d%0d: ready=%b busy=%b exp 0 0", nm, d, ready[d], busy[d]);
    end
  endtask

  task automatic rd_txn(input int d, input logic [11:0] a, input string nm);
    txn(d, 1'b1, 1'b0, 1'b0, a, 12'o0, 1'b0, 12'o0, 12'o0, 1'b0, nm);
  endtask

  task automatic check_reset_outputs(input int d, input string nm);
    checks++;
    if (ready[d] !== 1'b0 || err[d] !== 1'b0 || busy[d] !== 1'b0 || rdata[d] !== 12'o0) begin
      errors++;
      $display("FAIL %s d%0d: ready=%b err=%b busy=%b rdata=%o exp 0 0 0 0000",
               nm, d, ready[d], err[d], busy[d], rdata[d]);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      check_reset_outputs(d, "reset_outputs");
      rd_m[d] = 12'o0;
    end
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) idle_inputs(d);
    tick();
    apply_reset();
    tick();
  endtask

  task automatic test_preload_read();
    preload(0, 12'o0123, 12'o4567);
    rd_txn(0, 12'o0123, "preload_read");
    apply_reset();
    rd_txn(0, 12'o0123, "read_after_reset");
  endtask

  task automatic test_write_read();
    preload(1, 12'o0123, 12'o4567);
    rd_txn(1, 12'o0123, "w0_read");
    txn(1, 1'b0, 1'b1, 1'b0, 12'o0200, 12'o1234, 1'b0, 12'o0, 12'o0, 1'b0, "w0_write");
    rd_txn(1, 12'o0200, "w0_readback");
  endtask

  task automatic test_autoinc();
    for (int d = 0; d < 2; d++) begin
      preload(d, 12'o0010, 12'o7777);
      txn(d, 1'b1, 1'b0, 1'b1, 12'o0010, 12'o0, 1'b0, 12'o0, 12'o0, 1'b0, "ainc_wrap");
      rd_txn(d, 12'o0010, "ainc_stored");
      preload(d, 12'o0020, 12'o1357);
      txn(d, 1'b1, 1'b0, 1'b1, 12'o0020, 12'o0, 1'b0, 12'o0, 12'o0, 1'b0, "ainc_out_of_range");
      rd_txn(d, 12'o0020, "ainc_out_of_range_stored");
    end
  endtask

  task automatic test_illegal();
    preload(0, 12'o0300, 12'o0055);
    rd_txn(0, 12'o0123, "illegal_setup");
    txn(0, 1'b1, 1'b1, 1'b0, 12'o0300, 12'o1111, 1'b0, 12'o0, 12'o0, 1'b0, "illegal");
    rd_txn(0, 12'o0300, "illegal_stored");
  endtask

  task automatic test_reset_midop();
    bit saw_ready;
    // Write aborted in WAIT.
    preload(0, 12'o0400, 12'o0123);
    wren[0]  = 1'b1;
    addr[0]  = 12'o0400;
    wdata[0] = 12'o7070;
    saw_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tick();
      if (ready[0] === 1'b1) saw_ready = 1'b1;
    end
    idle_inputs(0);
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      tick();
      if (ready[0] === 1'b1) saw_ready = 1'b1;
    end
    checks++;
    if (saw_ready) begin
      errors++;
      $display("FAIL abort_write_ready: ready seen, exp none");
    end
    rd_txn(0, 12'o0400, "abort_write_stored");

    // Auto-index aborted in INCR (W+2 edges after the request is driven).
    preload(0, 12'o0011, 12'o0042);
    rden[0]    = 1'b1;
    autoinc[0] = 1'b1;
    addr[0]    = 12'o0011;
    saw_ready  = 1'b0;
    for (int n = 0; n < wv(0) + 2; n++) begin
      tick();
      if (ready[0] === 1'b1) saw_ready = 1'b1;
    end
    idle_inputs(0);
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      tick();
      if (ready[0] === 1'b1) saw_ready = 1'b1;
    end
    checks++;
    if (saw_ready) begin
      errors++;
      $display("FAIL abort_ainc_ready: ready seen, exp none");
    end
    rd_txn(0, 12'o0011, "abort_ainc_stored");
  endtask

  task automatic test_contention();
    preload(0, 12'o0500, 12'o0321);
    txn(0, 1'b1, 1'b0, 1'b0, 12'o0500, 12'o0, 1'b1, 12'o0500, 12'o7654, 1'b0, "ld_vs_read");
    rd_txn(0, 12'o0500, "ld_dropped");
    preload(0, 12'o7654, 12'o1111);
    txn(0, 1'b1, 1'b0, 1'b0, 12'o0123, 12'o0, 1'b0, 12'o0, 12'o0, 1'b1, "addr_toggle");
  endtask

  task automatic test_back_to_back();
    int rdy_cyc [$];
    int w;
    w = wv(0);
    rd_m[0] = mm[0][12'o0123];
    rden[0] = 1'b1;
    addr[0] = 12'o0123;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (ready[0] === 1'b1) begin
        rdy_cyc.push_back(n);
        checks++;
        if (rdata[0] !== rd_m[0]) begin
          errors++;
          $display("FAIL b2b_rdata: got %o exp %o", rdata[0], rd_m[0]);
        end
      end
      // Strobe held through the idle cycle after the first ready, then dropped.
      if (rdy_cyc.size() == 1 && n == rdy_cyc[0] + 2) rden[0] = 1'b0;
    end
    idle_inputs(0);
    checks++;
    if (rdy_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d readies exp 2", rdy_cyc.size());
    end else begin
      checks++;
      if (rdy_cyc[0] != w + 2 || rdy_cyc[1] != 2 * w + 5) begin
        errors++;
        $display("FAIL b2b_cycles: got %0d,%0d exp %0d,%0d",
                 rdy_cyc[0], rdy_cyc[1], w + 2, 2 * w + 5);
      end
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) preload(d, 12'(i), 12'($urandom_range(0, 4095)));
      for (int it = 0; it < 30; it++) begin
        int          kind;
        bit          rd, wr, ai, ld;
        logic [11:0] a, wd, lda, ldd;
        kind = int'($urandom_range(0, 4));
        a    = 12'($urandom_range(0, 31));
        wd   = 12'($urandom_range(0, 4095));
        ld   = ($urandom_range(0, 3) == 0);
        lda  = 12'($urandom_range(0, 31));
        ldd  = 12'($urandom_range(0, 4095));
        rd = 1'b1; wr = 1'b0; ai = 1'b0;
        case (kind)
          1: begin rd = 1'b0; wr = 1'b1; end
          2: begin ai = 1'b1; a = 12'($urandom_range(8, 15)); end
          3: ai = 1'b1;
          4: wr = 1'b1;
          default: ;
        endcase
        txn(d, rd, wr, ai, a, wd, ld, lda, ldd, 1'b0, "random");
      end
      for (int i = 0; i < 32; i++) rd_txn(d, 12'(i), "random_sweep");
    end
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_write_read();
    test_autoinc();
    test_illegal();
    test_reset_midop();
    test_contention();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
